usb_fs_tx_pkt_buf: RTL and testbench
====================================

Name: usb_fs_tx_pkt_buf

Overview:
- IN-endpoint packet source sitting directly upstream of usb_fs_tx, in the same `clk` domain as usb_fs_tx's packet interface.
- Application loads one packet of bytes and commits it. On each IN token the block launches a DATA0/DATA1, NAK or STALL packet into the transmitter.
- Serves payload bytes on tx_data_get pulses, waits for the host ACK, toggles the data PID, and retransmits on timeout or on a repeated IN token.

Parameters:
- MAX_PKT, 64, payload buffer depth in bytes (8..1023).
- ACK_TIMEOUT, 1024, `clk` cycles to wait for ACK after pkt_end before the packet is re-armed for retransmit.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write wr_data into the buffer.
- wr_data  in  8  payload byte.
- wr_full  out  1  buffer holds MAX_PKT bytes.
- commit  in  1  pulse: buffered bytes form a packet, ready to send.
- busy  out  1  high from commit until ACK; writes are ignored while high.
- stall  in  1  endpoint halted (level).
- data_toggle_clr  in  1  pulse: force next data PID to DATA0.
- in_token  in  1  pulse: IN token addressed to this endpoint received.
- ack_rcvd  in  1  pulse: host ACK handshake received.
- sent_ok  out  1  pulse: packet acknowledged, buffer freed.
- pkt_start  out  1  to usb_fs_tx.
- pid  out  4  to usb_fs_tx.
- pkt_end  in  1  from usb_fs_tx.
- tx_data_avail  out  1  to usb_fs_tx.
- tx_data_get  in  1  from usb_fs_tx.
- tx_data  out  8  to usb_fs_tx.

Behaviour:
- Reset values (reset_n=0 at a clk edge, valid at any point, including mid-packet):
  - State FILL, len=0, rd_ptr=0, toggle=DATA0.
  - All outputs 0: pkt_start, pid, tx_data_avail, tx_data, busy, wr_full, sent_ok.
- Pointer and length rules:
  - len and rd_ptr are $clog2(MAX_PKT+1) bits wide.
  - wr_full = (len == MAX_PKT).
- States: FILL, READY, SEND_DATA, WAIT_ACK, SEND_HS.
- FILL:
  - wr_en && !wr_full: write buf[len], then len++. wr_en while full is dropped and len is unchanged.
  - commit: go to READY, busy=1. commit with len=0 is legal and produces a zero-length packet.
  - wr_en and commit in the same cycle: the byte is included in the packet.
- IN token handling, evaluated in every state except SEND_DATA and SEND_HS (in those states in_token is ignored):
  - stall=1: pulse pkt_start, pid=4'b1110 (STALL), go to SEND_HS. STALL has priority over everything else.
  - Otherwise, state FILL: pkt_start, pid=4'b1010 (NAK), go to SEND_HS.
  - Otherwise, state READY or WAIT_ACK: rd_ptr=0, pkt_start, pid = toggle ? 4'b1011 : 4'b0011, go to SEND_DATA. An IN token during WAIT_ACK means the packet was lost, so the same toggle is retransmitted.
- pkt_start handshake:
  - pkt_start is exactly 1 cycle.
  - pid is valid in the pkt_start cycle and held until pkt_end.
- SEND_DATA:
  - tx_data = buf[rd_ptr], registered, valid 1 cycle after rd_ptr changes.
  - tx_data_avail = (rd_ptr != len), combinational.
  - Each tx_data_get increments rd_ptr; it saturates at len.
  - On pkt_end: go to WAIT_ACK and load the timeout counter with ACK_TIMEOUT-1.
- WAIT_ACK:
  - ack_rcvd: flip toggle, len=0, busy=0, pulse sent_ok, go to FILL.
  - Counter reaches 0: go to READY; the packet is retained.
  - ack_rcvd and in_token in the same cycle: ack wins.
- SEND_HS: on pkt_end, return to the state held before the handshake (FILL or READY).
- Other signal rules:
  - ack_rcvd outside WAIT_ACK is ignored.
  - data_toggle_clr sets toggle=DATA0 in any state. If asserted in WAIT_ACK together with ack_rcvd, the clear wins and toggle ends at DATA0.
  - stall rising while in WAIT_ACK: the packet is kept, and the next IN token receives STALL.

Optional Feature:
- Macro: USB_FS_TX_PKT_BUF_RETRY_CNT_EN.
- Defined: adds output retry_cnt[7:0], a saturating count of retransmissions (entry into SEND_DATA from WAIT_ACK, or from READY after a timeout). Cleared on reset and on sent_ok.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package usb_fs_pkg holds:
  - PID constants PID_DATA0, PID_DATA1, PID_NAK, PID_STALL, PID_ACK.
  - The state enum.
  - Function clog2 for pointer widths.
- Sub-module usb_fs_pkt_ram: MAX_PKT x 8 single-write, registered-read RAM, so the buffer infers block RAM.

Test Plan:
- Write 3 bytes 0x11,0x22,0x33, commit, in_token -> pkt_start with pid=0x3; three gets return 0x11,0x22,0x33; tx_data_avail drops after the third get; pkt_end then ack_rcvd -> sent_ok pulse, busy=0, and the next packet uses pid=0xB.
- in_token with empty buffer -> pid=0xA (NAK), state returns to FILL; with stall=1 and a packet loaded -> pid=0xE, packet retained.
- Loaded packet, pkt_end, no ACK for ACK_TIMEOUT cycles, then in_token -> resend with the same pid=0x3, bytes from index 0, retry_cnt=1 when the macro is defined.
- Write 65 bytes with MAX_PKT=64 -> wr_full=1 after 64 bytes, the 65th is dropped, packet length is 64; commit with 0 bytes -> DATA packet with tx_data_avail=0 throughout.
- reset_n=0 mid-SEND_DATA after 2 gets -> all outputs 0, toggle DATA0, the next in_token returns NAK.
- data_toggle_clr after two ACKed packets -> the third packet uses pid=0x3.

Source files
------------

// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: PID codes, IN-endpoint FSM states and a width helper shared by the USB FS transmit path.
package usb_fs_pkg;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  typedef enum logic [2:0] {FILL, READY, SEND_DATA, WAIT_ACK, SEND_HS} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/usb_fs_pkt_ram.sv
// usb_fs_pkt_ram: single-write, registered-read byte buffer shaped for block RAM inference.
module usb_fs_pkt_ram #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    rdata <= !reset_n ? '0 : mem[raddr];
endmodule

// File: rtl/usb_fs_tx_pkt_buf.sv
// usb_fs_tx_pkt_buf: IN-endpoint packet source feeding usb_fs_tx (DATA0/1, NAK, STALL, ACK wait, retransmit).
// Optional USB_FS_TX_PKT_BUF_RETRY_CNT_EN adds a saturating retransmission counter output.
module usb_fs_tx_pkt_buf
  import usb_fs_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  input  logic       commit,
  output logic       busy,
  input  logic       stall,
  input  logic       data_toggle_clr,
  input  logic       in_token,
  input  logic       ack_rcvd,
  output logic       sent_ok,
  output logic       pkt_start,
  output logic [3:0] pid,
  input  logic       pkt_end,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
  output logic [7:0] retry_cnt,
`endif
  output logic [7:0] tx_data
);
  localparam int AW = clog2(MAX_PKT + 1);
  localparam int IW = clog2(MAX_PKT);
  localparam int TW = clog2(ACK_TIMEOUT) + 1;
  state_t state, ret;
  logic [AW-1:0] len, rd_ptr;
  logic [TW-1:0] cnt;
  logic toggle, resent, we, tok, ack_w, hs, go;
  assign wr_full = len == AW'(MAX_PKT);
  assign tx_data_avail = state == SEND_DATA && rd_ptr != len;
  assign we = wr_en && !wr_full && state == FILL;
  assign tok = in_token && state != SEND_DATA && state != SEND_HS;
  assign ack_w = ack_rcvd && state == WAIT_ACK;
  assign hs = tok && !ack_w && (stall || state == FILL);
  assign go = tok && !ack_w && !stall && state != FILL;
  usb_fs_pkt_ram #(.DEPTH(MAX_PKT), .AW(IW)) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .we(we),
    .waddr(len[IW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[IW-1:0]),
    .rdata(tx_data)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= FILL;
      ret <= FILL;
      len <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      toggle <= 1'b0;
      resent <= 1'b0;
      busy <= 1'b0;
      sent_ok <= 1'b0;
      pkt_start <= 1'b0;
      pid <= '0;
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
      retry_cnt <= '0;
`endif
    end else begin
      pkt_start <= hs || go;
      sent_ok <= ack_w;
      toggle <= data_toggle_clr ? 1'b0 : toggle ^ ack_w;
      if (hs || go) pid <= stall ? PID_STALL : state == FILL ? PID_NAK : toggle ? PID_DATA1 : PID_DATA0;
      if (we) len <= len + 1'b1;
      // a handshake sent while committing must come back to READY so the packet is not lost
      if (hs) begin
        ret <= state == FILL && !commit ? FILL : READY;
        state <= SEND_HS;
      end
      if (go) begin
        rd_ptr <= '0;
        resent <= 1'b1;
        state <= SEND_DATA;
      end
      if (state == FILL && commit) begin
        busy <= 1'b1;
        if (!hs) state <= READY;
      end
      if (ack_w) begin
        len <= '0;
        busy <= 1'b0;
        resent <= 1'b0;
        state <= FILL;
      end else if (state == WAIT_ACK && !tok) begin
        if (cnt == '0) state <= READY;
        else cnt <= cnt - 1'b1;
      end
      if (state == SEND_DATA) begin
        if (tx_data_get && tx_data_avail) rd_ptr <= rd_ptr + 1'b1;
        if (pkt_end) begin
          cnt <= TW'(ACK_TIMEOUT - 1);
          state <= WAIT_ACK;
        end
      end
      if (state == SEND_HS && pkt_end) state <= ret;
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
      if (ack_w) retry_cnt <= '0;
      else if (go && resent && retry_cnt != 8'hff) retry_cnt <= retry_cnt + 1'b1;
`endif
    end
endmodule

// File: tb/tb_usb_fs_tx_pkt_buf.sv
// tb_usb_fs_tx_pkt_buf: scoreboard bench with a queue-based endpoint model and randomized traffic.
module tb_usb_fs_tx_pkt_buf;
  localparam int MAXP = 64;
  localparam int TO = 20;
  logic clk = 1'b0, reset_n = 1'b0;
  logic wr_en = 0, commit = 0, stall = 0, data_toggle_clr = 0, in_token = 0, ack_rcvd = 0;
  logic pkt_end = 0, tx_data_get = 0;
  logic [7:0] wr_data = '0;
  logic wr_full, busy, sent_ok, pkt_start, tx_data_avail;
  logic [3:0] pid;
  logic [7:0] tx_data;
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
  logic [7:0] retry_cnt;
  int exp_retry[$];
`endif
  int checks = 0, errors = 0;
  logic [3:0] exp_pid[$];
  logic [7:0] exp_byte[$];
  bit exp_sent[$];
  logic [3:0] e;
  logic [7:0] m_q[$];
  bit m_busy, m_tog, m_wait, m_stall, m_once;
  int m_retry;

  usb_fs_tx_pkt_buf #(.MAX_PKT(MAXP), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .commit(commit), .busy(busy), .stall(stall), .data_toggle_clr(data_toggle_clr),
    .in_token(in_token), .ack_rcvd(ack_rcvd), .sent_ok(sent_ok), .pkt_start(pkt_start),
    .pid(pid), .pkt_end(pkt_end), .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get),
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
    .retry_cnt(retry_cnt),
`endif
    .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pkt_start) begin
      if (exp_pid.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pid_unexpected: got %0h, required no packet", pid);
      end else begin
        e = exp_pid.pop_front();
        chk("pid", pid, e);
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
        if ((e == 4'h3 || e == 4'hB) && exp_retry.size() > 0) chk("retry_cnt", retry_cnt, exp_retry.pop_front());
`endif
      end
    end
    if (tx_data_get) begin
      if (exp_byte.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL byte_unexpected: got %0h, required no byte", tx_data);
      end else chk("tx_data", tx_data, exp_byte.pop_front());
    end
    if (sent_ok) begin
      if (exp_sent.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sent_ok_unexpected: got 1, required 0");
      end else chk("sent_ok", sent_ok, exp_sent.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    if (!m_busy && m_q.size() < MAXP) m_q.push_back(b);
    wr_en = 1;
    wr_data = b;
    tick();
    wr_en = 0;
  endtask

  task automatic do_commit();
    m_busy = 1;
    commit = 1;
    tick();
    commit = 0;
  endtask

  task automatic token(input int lim);
    bit dat;
    int n;
    dat = 0;
    if (m_stall) begin
      exp_pid.push_back(4'hE);
      m_wait = 0;
    end else if (!m_busy) exp_pid.push_back(4'hA);
    else begin
      dat = 1;
      exp_pid.push_back(m_tog ? 4'hB : 4'h3);
      foreach (m_q[i]) exp_byte.push_back(m_q[i]);
      if (m_once && m_retry < 255) m_retry++;
      m_once = 1;
`ifdef USB_FS_TX_PKT_BUF_RETRY_CNT_EN
      exp_retry.push_back(m_retry);
`endif
    end
    stall = m_stall;
    in_token = 1;
    tick();
    in_token = 0;
    stall = 0;
    m_stall = 0;
    chk("pkt_start", pkt_start, 1);
    tick();
    if (dat) begin
      n = 0;
      while (tx_data_avail && n < lim) begin
        tx_data_get = 1;
        tick();
        tx_data_get = 0;
        tick();
        n++;
      end
      if (n == lim && lim < m_q.size()) return;
      chk("get_count", n, m_q.size());
    end
    pkt_end = 1;
    tick();
    pkt_end = 0;
    if (dat) m_wait = 1;
  endtask

  task automatic ack(input bit clr);
    if (m_wait) begin
      exp_sent.push_back(1'b1);
      m_busy = 0;
      m_q.delete();
      m_tog = !m_tog;
      m_wait = 0;
      m_once = 0;
      m_retry = 0;
    end
    if (clr) m_tog = 0;
    ack_rcvd = 1;
    data_toggle_clr = clr;
    tick();
    ack_rcvd = 0;
    data_toggle_clr = 0;
  endtask

  task automatic timeout();
    repeat (TO + 2) tick();
    m_wait = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    chk("rst_pkt_start", pkt_start, 0);
    chk("rst_pid", pid, 0);
    chk("rst_avail", tx_data_avail, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_sent_ok", sent_ok, 0);
    m_q.delete();
    exp_byte.delete();
    m_busy = 0;
    m_tog = 0;
    m_wait = 0;
    m_stall = 0;
    m_once = 0;
    m_retry = 0;
    reset_n = 1;
    tick();
  endtask

  initial begin
    tick();
    do_reset();
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    do_commit();
    chk("busy_after_commit", busy, 1);
    token(1000);
    ack(0);
    chk("busy_after_ack", busy, 0);
    token(1000);
    wr(8'h5A);
    do_commit();
    m_stall = 1;
    token(1000);
    token(1000);
    ack(0);
    repeat (3) wr(8'($urandom_range(0, 255)));
    do_commit();
    token(1000);
    timeout();
    ack(0);
    token(1000);
    ack(0);
    for (int i = 0; i < MAXP; i++) wr(8'(i * 3 + 1));
    chk("wr_full_at_max", wr_full, 1);
    wr(8'hEE);
    chk("wr_full_after_drop", wr_full, 1);
    do_commit();
    token(1000);
    ack(0);
    do_commit();
    chk("avail_empty_pkt", tx_data_avail, 0);
    token(1000);
    ack(0);
    for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i));
    do_commit();
    token(2);
    do_reset();
    token(1000);
    for (int p = 0; p < 3; p++) begin
      wr(8'(8'h70 + p));
      do_commit();
      token(1000);
      ack(p == 1);
    end
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4) repeat ($urandom_range(1, 12)) wr(8'($urandom_range(0, 255)));
      else if (op < 6) do_commit();
      else if (op == 6) ack(1'($urandom_range(0, 1)));
      else begin
        m_stall = ($urandom_range(0, 4) == 0);
        token(1000);
        if (m_wait) begin
          case ($urandom_range(0, 2))
            0: begin
              repeat ($urandom_range(0, 5)) tick();
              ack(1'($urandom_range(0, 1)));
            end
            1: timeout();
            default: begin
              m_stall = ($urandom_range(0, 1) == 1);
              token(1000);
            end
          endcase
          if (m_wait) ack(0);
        end
      end
    end
    repeat (3) tick();
    chk("pid_queue_empty", exp_pid.size(), 0);
    chk("byte_queue_empty", exp_byte.size(), 0);
    chk("sent_queue_empty", exp_sent.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
